xadc_sample_filter: RTL and testbench
=====================================

# xadc_sample_filter

Downstream consumer of the XADC DRP read path. Captures conversion results when the XADC strobes DRDY and keeps only the selected channel. Block-averages them over a power-of-two window and presents each average through a one-entry valid/ready buffer. Also drives a thresholded `level` bit toward the network input logic.

## Interface
- `AVG_LOG2`, default 3: window is 2^AVG_LOG2 samples; legal range 0..4.
- `CHANNEL_SEL`, default 5'd0: XADC channel accepted (0 = on-chip temperature).
- `clk` in 1: single system clock, same clock as the DRP port.
- `rst` in 1: synchronous, active-high reset.
- `drdy` in 1: XADC DRP data-ready strobe; one cycle per read.
- `do_data` in 16: DRP read data; the ADC code is `do_data[15:4]`.
- `channel` in 5: XADC channel of the current result; sampled with `drdy`.
- `thresh_hi` in 12: upper threshold.
- `thresh_lo` in 12: lower threshold, used only with hysteresis.
- `avg_data` out 12: window average.
- `avg_valid` out 1: `avg_data` is held and valid.
- `avg_ready` in 1: consumer accepts `avg_data`.
- `level` out 1: thresholded state of the latest completed average.
- `overflow` out 1: sticky; a completed average was dropped.
- `sample_count` out 16: accepted samples since reset.

## Operation
- Accept condition: `drdy`=1 and `channel`==CHANNEL_SEL. All other cycles are ignored.
- Accepted sample:
  - code = `do_data[15:4]`.
  - `sample_count` increments by 1 and wraps 16'hFFFF→0.
- Accumulator:
  - Width 12+AVG_LOG2 bits, unsigned; it never overflows.
  - Window counter counts 0..2^AVG_LOG2−1.
- Window completion: the accepted sample with counter = 2^AVG_LOG2−1.
  - avg = (acc + code) >> AVG_LOG2, truncated, no rounding.
  - acc and counter clear on the same edge.
  - AVG_LOG2=0 means every accepted sample completes a window; avg = code.
- Output buffer FSM, two states:
  - EMPTY: `avg_valid`=0. A completion loads `avg_data` and moves to FULL.
  - FULL: `avg_valid`=1 and `avg_data` is stable.
    - `avg_ready`=1 with no completion → EMPTY.
    - `avg_ready`=1 with a completion → load the new average and stay FULL.
    - `avg_ready`=0 with a completion → new average dropped, `overflow` set, `avg_data` unchanged.
- `level` updates on every completion, including dropped ones, using the new avg (see Configuration).
- `overflow` clears only on `rst`.
- Reset mid-window: the partial window is discarded and the buffer is emptied.

## Timing
- Reset values:
  - `avg_data`=0, `avg_valid`=0, `level`=0, `overflow`=0, `sample_count`=0.
  - Internally, acc=0, window counter=0, FSM=EMPTY.
- Latency: completing `drdy` at edge t → `avg_valid`, `avg_data`, `level` and `overflow` change at edge t+1. All outputs are registered.
- Handshake: a transfer occurs on an edge where `avg_valid`=1 and `avg_ready`=1. `avg_valid` never depends combinationally on `avg_ready`.
- Throughput: one accepted sample per cycle (back-to-back `drdy`), one average per window.
- `rst` takes priority over every other input on the same edge.

## Configuration
- Macro: `XADC_HYSTERESIS_EN`.
- Defined:
  - avg >= `thresh_hi` → `level`=1.
  - avg <= `thresh_lo` → `level`=0.
  - Otherwise `level` holds.
  - If `thresh_lo` >= `thresh_hi`, the `thresh_hi` test wins.
- Undefined:
  - `level` = (avg >= `thresh_hi`).
  - `thresh_lo` is unused and ignored.

## Test plan
- Average: AVG_LOG2=2, four accepted `do_data` 16'h1000, 16'h2000, 16'h3000, 16'h4000 with `avg_ready`=1 → `avg_valid` for one cycle with `avg_data`=12'h280, one cycle after the 4th `drdy`; `sample_count`=4.
- Channel filter: CHANNEL_SEL=0; `drdy` with `channel`=3, `do_data`=16'hFFF0 interleaved among four channel-0 samples of 16'h1000 → `avg_data`=12'h100; `sample_count`=4.
- Back-pressure: `avg_ready`=0 across two complete windows (avg 12'h100 then 12'h200) → `avg_data` stays 12'h100 and `overflow`=1. Raising `avg_ready` → `avg_valid` drops next cycle and `overflow` stays 1.
- Simultaneous: window completes on the same edge `avg_ready`=1 with FULL → `avg_valid` stays 1, `avg_data` shows the new value, `overflow`=0.
- Hysteresis (macro defined): `thresh_hi`=12'h800, `thresh_lo`=12'h400; averages 12'h900, 12'h600, 12'h300 → `level` 1, 1, 0. With the macro undefined → `level` 1, 0, 0.
- Reset mid-window: after 2 of 4 samples, pulse `rst`, then 4 samples of 16'h2000 → `avg_data`=12'h200; `sample_count`=4.

Source files
------------

// File: rtl/xadc_sample_filter.sv
// Block-averages XADC DRP results for one channel and hands each average out through a
// one-entry valid/ready buffer; optional hysteresis on `level` via XADC_HYSTERESIS_EN.
module xadc_sample_filter #(
    parameter int unsigned AVG_LOG2    = 3,
    parameter logic [4:0]  CHANNEL_SEL = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        drdy,
    input  logic [15:0] do_data,
    input  logic [4:0]  channel,
    input  logic [11:0] thresh_hi,
    input  logic [11:0] thresh_lo,
    output logic [11:0] avg_data,
    output logic        avg_valid,
    input  logic        avg_ready,
    output logic        level,
    output logic        overflow,
    output logic [15:0] sample_count
);

    localparam int unsigned AccW = 12 + AVG_LOG2;
    localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

    typedef enum logic {StEmpty, StFull} state_t;

    state_t            state;
    logic [AccW-1:0]   acc;
    logic [AccW-1:0]   sum;
    logic [CntW-1:0]   cnt;
    logic [11:0]       code;
    logic [11:0]       avg;
    logic              accept;
    logic              last;
    logic              complete;
    logic              level_next;

    assign code     = do_data[15:4];
    assign accept   = drdy && (channel == CHANNEL_SEL);
    assign last     = (AVG_LOG2 == 0) || (cnt == CntLast);
    assign complete = accept && last;
    // Accumulator is sized so the full window sum fits; the top 12 bits are the mean.
    assign sum      = acc + AccW'(code);
    assign avg      = sum[AccW-1 -: 12];

`ifdef XADC_HYSTERESIS_EN
    logic unused_bits;
    assign unused_bits = ^do_data[3:0];

    always_comb begin
        level_next = level;
        if (avg >= thresh_hi) begin
            level_next = 1'b1;
        end else if (avg <= thresh_lo) begin
            level_next = 1'b0;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{thresh_lo, do_data[3:0]};

    always_comb begin
        level_next = (avg >= thresh_hi);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StEmpty;
            acc          <= '0;
            cnt          <= '0;
            avg_data     <= 12'h000;
            avg_valid    <= 1'b0;
            level        <= 1'b0;
            overflow     <= 1'b0;
            sample_count <= 16'h0000;
        end else begin
            if (accept) begin
                sample_count <= sample_count + 16'd1;
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CntW'(1);
                end
            end

            // Level tracks every completed average, even one the buffer has to drop.
            if (complete) begin
                level <= level_next;
            end

            case (state)
                StEmpty: begin
                    if (complete) begin
                        avg_data  <= avg;
                        avg_valid <= 1'b1;
                        state     <= StFull;
                    end
                end
                StFull: begin
                    if (complete) begin
                        if (avg_ready) begin
                            avg_data <= avg;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (avg_ready) begin
                        avg_valid <= 1'b0;
                        state     <= StEmpty;
                    end
                end
                default: begin
                    state     <= StEmpty;
                    avg_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_sample_filter.sv
// Bench for xadc_sample_filter: directed cases plus random traffic against a queue-based
// window/buffer model; follows XADC_HYSTERESIS_EN when defined for the whole build.
module tb_xadc_sample_filter;

    localparam int Win = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        drdy;
    logic [15:0] do_data;
    logic [4:0]  channel;
    logic [11:0] thresh_hi;
    logic [11:0] thresh_lo;
    logic [11:0] avg_data;
    logic        avg_valid;
    logic        avg_ready;
    logic        level;
    logic        overflow;
    logic [15:0] sample_count;

    always #5 clk = ~clk;

    xadc_sample_filter #(
        .AVG_LOG2    (2),
        .CHANNEL_SEL (5'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .drdy         (drdy),
        .do_data      (do_data),
        .channel      (channel),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .avg_data     (avg_data),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready),
        .level        (level),
        .overflow     (overflow),
        .sample_count (sample_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue holds the current window; the buffer is a valid bit plus data.
    int          win[$];
    logic        m_valid;
    logic        m_level;
    logic        m_ovf;
    logic [11:0] m_data;
    logic [15:0] m_cnt;

    task automatic model_clear();
        win.delete();
        m_valid = 1'b0;
        m_level = 1'b0;
        m_ovf   = 1'b0;
        m_data  = 12'h000;
        m_cnt   = 16'h0000;
    endtask

    task automatic model_step();
        int sum;
        int avg;
        bit done;
        done = 1'b0;
        avg  = 0;
        if (rst) begin
            model_clear();
            return;
        end
        if (drdy && channel == 5'd0) begin
            m_cnt = m_cnt + 16'd1;
            win.push_back(int'(do_data[15:4]));
            if (win.size() == Win) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                avg  = sum / Win;
                done = 1'b1;
                win.delete();
            end
        end
        if (done) begin
`ifdef XADC_HYSTERESIS_EN
            if (avg >= int'(thresh_hi)) m_level = 1'b1;
            else if (avg <= int'(thresh_lo)) m_level = 1'b0;
`else
            m_level = (avg >= int'(thresh_hi));
`endif
            if (!m_valid || avg_ready) begin
                m_data  = avg[11:0];
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && avg_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cyc(input logic r, input logic d, input logic [15:0] dat,
                       input logic [4:0] ch, input logic rdy);
        rst       = r;
        drdy      = d;
        do_data   = dat;
        channel   = ch;
        avg_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        check("avg_valid", {31'd0, avg_valid}, {31'd0, m_valid});
        check("avg_data", {20'd0, avg_data}, {20'd0, m_data});
        check("level", {31'd0, level}, {31'd0, m_level});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("sample_count", {16'd0, sample_count}, {16'd0, m_cnt});
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 16'h0000, 5'd0, 1'b0);
    endtask

    task automatic win4(input logic [15:0] dat, input logic rdy);
        for (int i = 0; i < Win; i++) cyc(1'b0, 1'b1, dat, 5'd0, rdy);
    endtask

    initial begin
        model_clear();
        thresh_hi = 12'h800;
        thresh_lo = 12'h400;

        do_reset();
        do_reset();
        check("rst_valid", {31'd0, avg_valid}, 32'd0);
        check("rst_data", {20'd0, avg_data}, 32'd0);
        check("rst_level", {31'd0, level}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_count", {16'd0, sample_count}, 32'd0);

        // Average of four distinct codes
        cyc(1'b0, 1'b1, 16'h1000, 5'd0, 1'b1);
        cyc(1'b0, 1'b1, 16'h2000, 5'd0, 1'b1);
        cyc(1'b0, 1'b1, 16'h3000, 5'd0, 1'b1);
        check("avg_not_yet", {31'd0, avg_valid}, 32'd0);
        cyc(1'b0, 1'b1, 16'h4000, 5'd0, 1'b1);
        check("avg_valid_280", {31'd0, avg_valid}, 32'd1);
        check("avg_280", {20'd0, avg_data}, 32'h280);
        check("avg_count4", {16'd0, sample_count}, 32'd4);
        cyc(1'b0, 1'b0, 16'h0000, 5'd0, 1'b1);
        check("avg_one_cycle", {31'd0, avg_valid}, 32'd0);

        // Channel filter
        do_reset();
        for (int i = 0; i < Win; i++) begin
            cyc(1'b0, 1'b1, 16'hFFF0, 5'd3, 1'b0);
            cyc(1'b0, 1'b1, 16'h1000, 5'd0, 1'b0);
        end
        check("chan_avg", {20'd0, avg_data}, 32'h100);
        check("chan_count", {16'd0, sample_count}, 32'd4);

        // Back-pressure across two windows
        do_reset();
        win4(16'h1000, 1'b0);
        win4(16'h2000, 1'b0);
        check("bp_data", {20'd0, avg_data}, 32'h100);
        check("bp_ovf", {31'd0, overflow}, 32'd1);
        cyc(1'b0, 1'b0, 16'h0000, 5'd0, 1'b1);
        check("bp_drain", {31'd0, avg_valid}, 32'd0);
        check("bp_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Completion coinciding with a transfer
        do_reset();
        win4(16'h1000, 1'b0);
        for (int i = 0; i < Win - 1; i++) cyc(1'b0, 1'b1, 16'h2000, 5'd0, 1'b0);
        cyc(1'b0, 1'b1, 16'h2000, 5'd0, 1'b1);
        check("sim_valid", {31'd0, avg_valid}, 32'd1);
        check("sim_data", {20'd0, avg_data}, 32'h200);
        check("sim_ovf", {31'd0, overflow}, 32'd0);

        // Threshold behaviour
        do_reset();
        win4(16'h9000, 1'b1);
        check("lvl_900", {31'd0, level}, 32'd1);
        win4(16'h6000, 1'b1);
`ifdef XADC_HYSTERESIS_EN
        check("lvl_600", {31'd0, level}, 32'd1);
`else
        check("lvl_600", {31'd0, level}, 32'd0);
`endif
        win4(16'h3000, 1'b1);
        check("lvl_300", {31'd0, level}, 32'd0);

        // Reset mid-window
        do_reset();
        cyc(1'b0, 1'b1, 16'hF000, 5'd0, 1'b1);
        cyc(1'b0, 1'b1, 16'hF000, 5'd0, 1'b1);
        do_reset();
        win4(16'h2000, 1'b0);
        check("midrst_data", {20'd0, avg_data}, 32'h200);
        check("midrst_count", {16'd0, sample_count}, 32'd4);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic        d;
            logic [4:0]  ch;
            logic        rdy;
            logic [15:0] dat;
            if ($urandom_range(0, 49) == 0) begin
                thresh_hi = 12'($urandom);
                thresh_lo = 12'($urandom);
            end
            r   = ($urandom_range(0, 299) == 0);
            d   = ($urandom_range(0, 9) < 7);
            ch  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            rdy = ($urandom_range(0, 3) != 0);
            dat = 16'($urandom);
            cyc(r, d, dat, ch, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
